ram_bist_ctrl: RTL and testbench
================================

// Module: ram_bist_ctrl
//
// PURPOSE
//   Initiator-side controller for a single-port block_ram (we/addr/din/dout, registered read).
//   On a start pulse it writes a data pattern to every address, reads each one back and
//   compares, then repeats with the complemented pattern. It reports pass/fail, an error
//   count and the first failing address. It sits between a control/status source and the RAM port.
//
// PARAMETERS
//   ADDR_WIDTH  8     RAM address width; DEPTH = 2**ADDR_WIDTH words tested
//   DATA_WIDTH  8     RAM data width
//   SEED        8'hA5 pattern seed (DATA_WIDTH bits)
//   RD_LATENCY  1     cycles from ram_addr sampled to ram_dout valid (>=1)
//
// PORTS
//   clk             in   1           system clock, all logic on posedge
//   rst             in   1           synchronous, active-high reset
//   start           in   1           one-cycle request; honoured only when busy=0
//   busy            out  1           test in progress
//   done            out  1           test complete; held until next start or rst
//   pass            out  1           valid when done=1; 1 iff err_count==0
//   err_count       out  ADDR_WIDTH+1  mismatching reads, saturating
//   first_err_addr  out  ADDR_WIDTH  address of first mismatch (0 if none)
//   ram_we          out  1           RAM write enable
//   ram_addr        out  ADDR_WIDTH  RAM address
//   ram_din         out  DATA_WIDTH  RAM write data
//   ram_dout        in   DATA_WIDTH  RAM read data
//
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE. rst mid-test aborts at that edge; ram_we=0 next cycle.
//   - States: IDLE -> W0 -> R0 -> D0 -> W1 -> R1 -> D1 -> DONE -> (start) W0.
//   - start in IDLE or DONE: clears done/pass/err_count/first_err_addr, busy=1 next cycle,
//     enters W0. start while busy is ignored.
//   - pattern(a,p) = ({DATA_WIDTH{p}}) ^ SEED ^ a, a zero-extended/truncated to DATA_WIDTH.
//   - W0/W1: one write per cycle, addr 0..DEPTH-1; ram_we=1, ram_din=pattern(addr, 0/1).
//   - R0/R1: ram_we=0, one read per cycle, addr 0..DEPTH-1. Issued addr and valid flag travel
//     a RD_LATENCY-deep shift pipeline; compare ram_dout to pattern(tagged addr, pass) when
//     the tag emerges.
//   - D0/D1: RD_LATENCY cycles with no new reads; drain outstanding compares.
//   - Address counter wraps DEPTH-1 -> 0 exactly at each phase change; no idle cycle between phases.
//   - Mismatch: err_count+1, saturating at all-ones; first_err_addr loaded only on first mismatch.
//   - DONE: busy=0, done=1, pass=(err_count==0); ram_we=0, ram_addr held at 0.
//   - Total run: start edge to done=1 = 4*DEPTH + 2*RD_LATENCY + 1 cycles.
//   - Mismatch and saturation in the same cycle: count stays all-ones; first_err_addr rule unchanged.
//
// STRUCTURE
//   - Package ram_bist_pkg: state enum (IDLE,W0,R0,D0,W1,R1,D1,DONE), pattern() function.
//   - Sub-module ram_bist_rdpipe: parameterised RD_LATENCY shift of {valid, addr, pass_sel}.
//   - Top holds FSM, address counter, comparator, status registers.
//
// TESTING  (ADDR_WIDTH=4, DATA_WIDTH=8, SEED=8'hA5, RD_LATENCY=1, behavioural block_ram)
//   1. Clean RAM, 1-cycle start -> done=1 after 67 cycles; pass=1, err_count=0.
//      W0 addr 3 ram_din=8'hA6; W1 addr 3 ram_din=8'h59.
//   2. RAM model forces bit0=0 at addr 5 -> W0 data 8'hA0 passes, W1 data 8'h5F fails;
//      err_count=1, first_err_addr=5, pass=0.
//   3. Model faults addr 2 and 9, both passes -> err_count=4, first_err_addr=2.
//   4. start pulsed again at cycle 20 of a run -> ignored; done still at cycle 67, result unchanged.
//   5. rst asserted during W1 -> next cycle all outputs 0, ram_we=0;
//      a later start completes clean in 67 cycles.
//   6. RD_LATENCY=2 with 2-cycle RAM model -> pass=1 in 69 cycles.
//      Same instance with 1-cycle model -> pass=0, err_count>0.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the block-RAM BIST controller.
// Pattern helper is sized for data paths up to PAT_MAX_W bits; callers truncate.
package ram_bist_pkg;

    localparam int unsigned PAT_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0,
        D0,
        W1,
        R1,
        D1,
        DONE
    } bist_state_e;

    // Test word for address a in pass p: all-p word xor seed xor address.
    function automatic logic [PAT_MAX_W-1:0] pattern(
        input logic [PAT_MAX_W-1:0] a,
        input logic                 p,
        input logic [PAT_MAX_W-1:0] seed
    );
        return {PAT_MAX_W{p}} ^ seed ^ a;
    endfunction

endpackage

// File: rtl/ram_bist_rdpipe.sv
// Read-tag delay line: carries {valid, pass select, address} alongside the RAM read latency.
module ram_bist_rdpipe #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sel,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic                  out_sel,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    localparam int unsigned TAG_W = ADDR_WIDTH + 2;

    logic [TAG_W-1:0] stage [RD_LATENCY];

    // Reset flushes in-flight tags so an aborted run cannot leave a stale compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= {in_valid, in_sel, in_addr};
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign {out_valid, out_sel, out_addr} = stage[RD_LATENCY-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style BIST for a single-port block RAM: write/read-compare with a seeded
// pattern, then again with its complement; reports pass, error count and first bad address.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(8'hA5),
    parameter int unsigned           RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned ERR_W = ADDR_WIDTH + 1;
    localparam int unsigned DRN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [DRN_W-1:0]      LAST_DRAIN = DRN_W'(RD_LATENCY - 1);

    bist_state_e           state, state_d;
    logic [ADDR_WIDTH-1:0] addr, addr_d;
    logic [DRN_W-1:0]      drain, drain_d;
    logic                  busy_d, done_d, pass_d, we_d;
    logic [ERR_W-1:0]      err_d;
    logic [ADDR_WIDTH-1:0] first_d;
    logic [DATA_WIDTH-1:0] din_d;

    logic                  pipe_valid, pipe_sel;
    logic [ADDR_WIDTH-1:0] pipe_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  mismatch;

    ram_bist_rdpipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  ((state == R0) || (state == R1)),
        .in_sel    (state == R1),
        .in_addr   (addr),
        .out_valid (pipe_valid),
        .out_sel   (pipe_sel),
        .out_addr  (pipe_addr)
    );

    assign exp_data = DATA_WIDTH'(pattern(PAT_MAX_W'(pipe_addr), pipe_sel, PAT_MAX_W'(SEED)));
    assign mismatch = pipe_valid && (ram_dout != exp_data);
    assign ram_addr = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            drain          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            ram_we         <= 1'b0;
            ram_din        <= '0;
        end else begin
            state          <= state_d;
            addr           <= addr_d;
            drain          <= drain_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_d;
            first_err_addr <= first_d;
            ram_we         <= we_d;
            ram_din        <= din_d;
        end
    end

    always_comb begin
        state_d = state;
        addr_d  = addr;
        drain_d = drain;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_count;
        first_d = first_err_addr;

        // Comparator: saturating count, first address latched while count is still zero.
        if (mismatch) begin
            if (err_count != '1) begin
                err_d = err_count + ERR_W'(1);
            end
            if (err_count == '0) begin
                first_d = pipe_addr;
            end
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = W0;
                    addr_d  = '0;
                    drain_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            W0, R0, W1, R1: begin
                // Natural wrap returns the counter to 0 on the same edge as the phase change.
                addr_d = addr + ADDR_WIDTH'(1);
                if (addr == LAST_ADDR) begin
                    state_d = (state == W0) ? R0 :
                              (state == R0) ? D0 :
                              (state == W1) ? R1 : D1;
                end
            end
            D0, D1: begin
                drain_d = drain + DRN_W'(1);
                if (drain == LAST_DRAIN) begin
                    drain_d = '0;
                    if (state == D0) begin
                        state_d = W1;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        we_d  = (state_d == W0) || (state_d == W1);
        din_d = we_d ? DATA_WIDTH'(pattern(PAT_MAX_W'(addr_d), state_d == W1, PAT_MAX_W'(SEED)))
                     : '0;
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: two instances (read latency 1 and 2) against
// behavioural RAMs with stuck-at-0 fault masks and a per-run result model.
module tb_ram_bist_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int SAT   = 31;
    localparam logic [7:0] SEED = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start1, start2;
    logic          busy1, done1, pass1, we1, busy2, done2, pass2, we2;
    logic [AW:0]   err1, err2;
    logic [AW-1:0] first1, addr1, first2, addr2;
    logic [DW-1:0] din1, dout1, din2, dout2;

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(SEED), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_addr(first1), .ram_we(we1), .ram_addr(addr1),
        .ram_din(din1), .ram_dout(dout1)
    );

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(SEED), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_addr(first2), .ram_we(we2), .ram_addr(addr2),
        .ram_din(din2), .ram_dout(dout2)
    );

    // Behavioural RAMs; mask bits force the read data to 0 (stuck-at-0 cells).
    logic [7:0] mem1 [DEPTH];
    logic [7:0] mask1 [DEPTH];
    logic [7:0] rd1;
    logic [7:0] mem2 [DEPTH];
    logic [7:0] mask2 [DEPTH];
    logic [7:0] rd2a, rd2b;
    int lat2;

    always @(posedge clk) begin
        if (we1) mem1[addr1] <= din1;
        rd1 <= mem1[addr1] & ~mask1[addr1];
        if (we2) mem2[addr2] <= din2;
        rd2a <= mem2[addr2] & ~mask2[addr2];
        rd2b <= rd2a;
    end
    assign dout1 = rd1;
    assign dout2 = (lat2 == 2) ? rd2b : rd2a;

    typedef struct {
        int start_cyc;
        int lat;
        bit any_fail;
        int exp_err;
        int exp_first;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int tests = 0, fails = 0, cyc = 0;
    int done_cnt1 = 0, done_cnt2 = 0, wr_cnt1 = 0, wa;
    logic [7:0] wexp;
    bit done1_q = 1'b0, done2_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected result straight from the rules: visit pass 0 then pass 1, addresses ascending.
    function automatic void ref_model(input logic [7:0] m [DEPTH], output int err, output int first);
        logic [7:0] pat;
        err   = 0;
        first = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                pat = SEED ^ 8'(a) ^ ((p == 1) ? 8'hFF : 8'h00);
                if ((pat & m[a]) != 8'h00) begin
                    if (err == 0) first = a;
                    if (err < SAT) err++;
                end
            end
        end
    endfunction

    task automatic score(input exp_t e, input logic ps, input logic [AW:0] er,
                         input logic [AW-1:0] fa, input string tag);
        check({tag, " cycles"}, cyc - e.start_cyc, e.lat);
        if (e.any_fail) begin
            check({tag, " pass"}, int'(ps), 0);
            check({tag, " err nonzero"}, int'(er != '0), 1);
        end else begin
            check({tag, " pass"}, int'(ps), int'(e.exp_err == 0));
            check({tag, " err_count"}, int'(er), e.exp_err);
            check({tag, " first_err_addr"}, int'(fa), e.exp_first);
        end
    endtask

    // Monitor for instance 1: every write checked, result popped on done rising.
    always @(negedge clk) begin
        if (rst) begin
            wr_cnt1 = 0;
        end else begin
            if (start1 && !busy1) wr_cnt1 = 0;
            if (we1) begin
                wa   = wr_cnt1 % DEPTH;
                wexp = SEED ^ 8'(wa) ^ ((wr_cnt1 >= DEPTH) ? 8'hFF : 8'h00);
                check("dut1 write addr", int'(addr1), wa);
                check("dut1 write data", int'(din1), int'(wexp));
                wr_cnt1++;
            end
            if (done1 && !done1_q) begin
                if (q1.size() == 0) begin
                    check("dut1 unexpected done", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    score(e1, pass1, err1, first1, "dut1");
                    check("dut1 done busy", int'(busy1), 0);
                    check("dut1 done ram_we", int'(we1), 0);
                    check("dut1 done ram_addr", int'(addr1), 0);
                end
                done_cnt1++;
            end
        end
        done1_q = done1;
    end

    always @(negedge clk) begin
        if (!rst && done2 && !done2_q) begin
            if (q2.size() == 0) begin
                check("dut2 unexpected done", 1, 0);
            end else begin
                e2 = q2.pop_front();
                score(e2, pass2, err2, first2, "dut2");
                check("dut2 done busy", int'(busy2), 0);
            end
            done_cnt2++;
        end
        done2_q = done2;
    end

    task automatic run_bist(input int which, input int extra, input bit any_fail);
        exp_t e;
        int n;
        if (which == 1) ref_model(mask1, e.exp_err, e.exp_first);
        else            ref_model(mask2, e.exp_err, e.exp_first);
        e.lat      = 4 * DEPTH + 2 * ((which == 1) ? 1 : 2) + 1;
        e.any_fail = any_fail;
        @(posedge clk); #1;
        e.start_cyc = cyc;
        n = (which == 1) ? done_cnt1 : done_cnt2;
        if (which == 1) begin q1.push_back(e); start1 = 1'b1; end
        else            begin q2.push_back(e); start2 = 1'b1; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        if (extra > 0) begin
            repeat (extra - 1) @(posedge clk);
            #1;
            if (which == 1) start1 = 1'b1; else start2 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            start2 = 1'b0;
        end
        for (int i = 0; i < 400 && (((which == 1) ? done_cnt1 : done_cnt2) == n); i++)
            @(posedge clk);
        if (((which == 1) ? done_cnt1 : done_cnt2) == n) begin
            check("run timeout", 0, 1);
            if (which == 1) q1.delete(); else q2.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_masks();
        for (int a = 0; a < DEPTH; a++) begin
            mask1[a] = 8'h00;
            mask2[a] = 8'h00;
        end
    endtask

    task automatic check_zero1(input string tag);
        check({tag, " busy"}, int'(busy1), 0);
        check({tag, " done"}, int'(done1), 0);
        check({tag, " pass"}, int'(pass1), 0);
        check({tag, " err_count"}, int'(err1), 0);
        check({tag, " first_err_addr"}, int'(first1), 0);
        check({tag, " ram_we"}, int'(we1), 0);
        check({tag, " ram_addr"}, int'(addr1), 0);
        check({tag, " ram_din"}, int'(din1), 0);
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        lat2   = 2;
        clear_masks();
        repeat (3) @(posedge clk);
        #1;
        check_zero1("reset");
        check("reset dut2 busy", int'(busy2), 0);
        rst = 1'b0;

        // Clean memory, single stuck bit, two double-bit faults, ignored restart.
        run_bist(1, 0, 1'b0);
        mask1[5] = 8'h01;
        run_bist(1, 0, 1'b0);
        clear_masks();
        mask1[2] = 8'h09;
        mask1[9] = 8'h09;
        run_bist(1, 0, 1'b0);
        clear_masks();
        run_bist(1, 20, 1'b0);

        // Every read fails: counter must saturate at all-ones.
        for (int a = 0; a < DEPTH; a++) mask1[a] = 8'hFF;
        run_bist(1, 0, 1'b0);

        repeat (4) begin
            for (int a = 0; a < DEPTH; a++)
                mask1[a] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_bist(1, 0, 1'b0);
        end

        // Abort during the complement write pass, then a clean rerun.
        clear_masks();
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("abort precondition busy", int'(busy1), 1);
        check("abort precondition ram_we", int'(we1), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero1("abort");
        rst = 1'b0;
        run_bist(1, 0, 1'b0);

        // Latency-2 instance: matched RAM passes, 1-cycle RAM must fail.
        lat2 = 2;
        run_bist(2, 0, 1'b0);
        lat2 = 1;
        run_bist(2, 0, 1'b1);

        check("scoreboard drained", q1.size() + q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
